// File: rtl/bcdn_counter.sv
// N-digit BCD up/down counter with parallel load, wrap/saturate boundary
// handling and registered overflow / load-error pulses.
module bcdn_counter #(
  parameter int unsigned DIGITS   = 4,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  ovf,
  output logic                  load_err,
  output logic                  is_zero,
  output logic                  is_max
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] count_q, count_d, step_val;
  logic         ovf_q, ovf_d, load_err_q, load_err_d;
  logic         load_ok, carry, all_nine;

  always_comb begin
    load_ok = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (load_val[4*k +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  // Ripple the step through the digits; a carry out of the top digit marks
  // a step attempted from the boundary (all-9s up, all-0s down).
  always_comb begin
    step_val = count_q;
    carry    = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (up) begin
          if (count_q[4*k +: 4] == 4'd9) begin
            step_val[4*k +: 4] = '0;
          end else begin
            step_val[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
            carry              = 1'b0;
          end
        end else begin
          if (count_q[4*k +: 4] == 4'd0) begin
            step_val[4*k +: 4] = 4'd9;
          end else begin
            step_val[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
            carry              = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    all_nine = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (count_q[4*k +: 4] != 4'd9) all_nine = 1'b0;
    end
  end

  always_comb begin
    count_d    = count_q;
    ovf_d      = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) count_d    = load_val;
      else         load_err_d = 1'b1;
    end else if (en) begin
      ovf_d = carry;
      if (!(carry && SATURATE)) count_d = step_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      ovf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign ovf      = ovf_q;
  assign load_err = load_err_q;
  assign is_zero  = (count_q == '0);
  assign is_max   = all_nine;

endmodule

// File: tb/tb_bcdn_counter.sv
// Bench for bcdn_counter: four instances (2/3/4 digits, wrap and saturate)
// share stimulus and are checked against an integer reference model.
module tb_bcdn_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0;
  logic [15:0] load_val = '0;

  logic [7:0]  c2;
  logic [11:0] c3;
  logic [15:0] c4w, c4s;
  logic        ovf2, ovf3, ovf4w, ovf4s;
  logic        err2, err3, err4w, err4s;
  logic        z2, z3, z4w, z4s, m2, m3, m4w, m4s;

  always #5 clk = ~clk;

  bcdn_counter #(.DIGITS(2), .SATURATE(1'b0)) u_d2 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val[7:0]), .count(c2), .ovf(ovf2), .load_err(err2),
    .is_zero(z2), .is_max(m2));
  bcdn_counter #(.DIGITS(3), .SATURATE(1'b0)) u_d3 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val[11:0]), .count(c3), .ovf(ovf3), .load_err(err3),
    .is_zero(z3), .is_max(m3));
  bcdn_counter #(.DIGITS(4), .SATURATE(1'b0)) u_d4w (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(c4w), .ovf(ovf4w), .load_err(err4w),
    .is_zero(z4w), .is_max(m4w));
  bcdn_counter #(.DIGITS(4), .SATURATE(1'b1)) u_d4s (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(c4s), .ovf(ovf4s), .load_err(err4s),
    .is_zero(z4s), .is_max(m4s));

  logic [15:0] dut_cnt [4];
  logic        dut_ovf [4], dut_err [4], dut_z [4], dut_m [4];
  assign dut_cnt[0] = {8'h00, c2};
  assign dut_cnt[1] = {4'h0, c3};
  assign dut_cnt[2] = c4w;
  assign dut_cnt[3] = c4s;
  assign dut_ovf = '{ovf2, ovf3, ovf4w, ovf4s};
  assign dut_err = '{err2, err3, err4w, err4s};
  assign dut_z   = '{z2, z3, z4w, z4s};
  assign dut_m   = '{m2, m3, m4w, m4s};

  int total = 0;
  int bad   = 0;

  // Reference model: plain integer count modulo 10^DIGITS.
  int dig [4] = '{2, 3, 4, 4};
  bit sat [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  int mval [4];
  bit movf [4], merr [4];

  function automatic int pow10(int n);
    int r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r = '0;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic void model_update(bit r, bit ld, logic [15:0] lv, bit e, bit u);
    for (int i = 0; i < 4; i++) begin
      int maxv = pow10(dig[i]) - 1;
      if (r) begin
        mval[i] = 0; movf[i] = 0; merr[i] = 0;
      end else if (ld) begin
        bit ok = 1;
        int v = 0;
        for (int k = 0; k < dig[i]; k++) begin
          int nib = int'(lv[4*k +: 4]);
          if (nib > 9) ok = 0;
          v = v + nib * pow10(k);
        end
        movf[i] = 0;
        merr[i] = !ok;
        if (ok) mval[i] = v;
      end else if (e) begin
        merr[i] = 0;
        if (u) begin
          movf[i] = (mval[i] == maxv);
          if (mval[i] == maxv) mval[i] = sat[i] ? maxv : 0;
          else mval[i] = mval[i] + 1;
        end else begin
          movf[i] = (mval[i] == 0);
          if (mval[i] == 0) mval[i] = sat[i] ? 0 : maxv;
          else mval[i] = mval[i] - 1;
        end
      end else begin
        movf[i] = 0; merr[i] = 0;
      end
    end
  endfunction

  task automatic step(input bit r, input bit ld, input logic [15:0] lv,
                      input bit e, input bit u);
    reset = r; load = ld; load_val = lv; en = e; up = u;
    @(posedge clk);
    model_update(r, ld, lv, e, u);
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, '0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (dut_cnt[i] !== 16'h0000 || dut_ovf[i] !== 1'b0 || dut_err[i] !== 1'b0 ||
          dut_z[i] !== 1'b1 || dut_m[i] !== 1'b0) begin
        bad++;
        $display("FAIL reset inst=%0d got cnt=%h ovf=%b err=%b z=%b m=%b want 0000 0 0 1 0",
                 i, dut_cnt[i], dut_ovf[i], dut_err[i], dut_z[i], dut_m[i]);
      end
    end
  endtask

  task automatic test_count_up();
    for (int n = 1; n <= 100; n++) begin
      step(0, 0, '0, 1, 1);
      total++;
      if (c2 !== to_bcd(n % 100)[7:0] || ovf2 !== (n == 100) || m2 !== (n == 99) ||
          z2 !== (n == 100)) begin
        bad++;
        $display("FAIL count_up n=%0d got cnt=%h ovf=%b max=%b zero=%b want cnt=%0d ovf=%b max=%b",
                 n, c2, ovf2, m2, z2, n % 100, n == 100, n == 99);
      end
    end
  endtask

  task automatic test_down_boundary();
    step(0, 1, 16'h1000, 0, 0);
    step(0, 0, '0, 1, 0);
    total++;
    if (c4w !== 16'h0999 || ovf4w !== 1'b0 || c4s !== 16'h0999 || ovf4s !== 1'b0) begin
      bad++;
      $display("FAIL down_borrow got w=%h/%b s=%h/%b want 0999/0", c4w, ovf4w, c4s, ovf4s);
    end
    step(0, 1, 16'h0000, 0, 0);
    step(0, 0, '0, 1, 0);
    total++;
    if (c4w !== 16'h9999 || ovf4w !== 1'b1) begin
      bad++;
      $display("FAIL down_wrap got %h ovf=%b want 9999 ovf=1", c4w, ovf4w);
    end
    for (int n = 0; n < 3; n++) begin
      total++;
      if (c4s !== 16'h0000 || ovf4s !== 1'b1) begin
        bad++;
        $display("FAIL down_sat n=%0d got %h ovf=%b want 0000 ovf=1", n, c4s, ovf4s);
      end
      step(0, 0, '0, 1, 0);
    end
    step(0, 0, '0, 0, 0);
    total++;
    if (ovf4s !== 1'b0 || ovf4w !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear got s=%b w=%b want 0", ovf4s, ovf4w);
    end
  endtask

  task automatic test_load_err();
    step(0, 1, 16'h0123, 0, 0);
    step(0, 1, 16'h01A5, 1, 1);
    total++;
    if (c3 !== 12'h123 || err3 !== 1'b1 || ovf3 !== 1'b0) begin
      bad++;
      $display("FAIL load_reject got %h err=%b ovf=%b want 123 err=1 ovf=0", c3, err3, ovf3);
    end
    step(0, 0, '0, 0, 0);
    total++;
    if (c3 !== 12'h123 || err3 !== 1'b0) begin
      bad++;
      $display("FAIL load_err_pulse got %h err=%b want 123 err=0", c3, err3);
    end
    step(0, 1, 16'h0159, 0, 0);
    total++;
    if (c3 !== 12'h159 || err3 !== 1'b0) begin
      bad++;
      $display("FAIL load_ok got %h err=%b want 159 err=0", c3, err3);
    end
  endtask

  task automatic test_load_priority();
    step(0, 1, 16'h0037, 0, 0);
    step(0, 1, 16'h0080, 1, 1);
    total++;
    if (c2 !== 8'h80 || ovf2 !== 1'b0) begin
      bad++;
      $display("FAIL load_priority got %h ovf=%b want 80 ovf=0", c2, ovf2);
    end
    step(0, 0, '0, 1, 1);
    total++;
    if (c2 !== 8'h81) begin
      bad++;
      $display("FAIL after_load got %h want 81", c2);
    end
  endtask

  task automatic test_reset_mid();
    step(0, 1, 16'h0044, 0, 0);
    step(0, 0, '0, 1, 1);
    step(1, 1, 16'h00AB, 1, 1);
    total++;
    if (c2 !== 8'h00 || ovf2 !== 1'b0 || err2 !== 1'b0 || c4w !== 16'h0000) begin
      bad++;
      $display("FAIL reset_mid got %h ovf=%b err=%b w=%h want 00 0 0 0000", c2, ovf2, err2, c4w);
    end
    step(0, 0, '0, 1, 1);
    total++;
    if (c2 !== 8'h01) begin
      bad++;
      $display("FAIL resume got %h want 01", c2);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 10000; n++) begin
      bit r  = ($urandom_range(199) == 0);
      bit ld = ($urandom_range(9) == 0);
      bit e  = ($urandom_range(3) != 0);
      bit u  = $urandom_range(1);
      logic [15:0] lv;
      case ($urandom_range(3))
        0: lv = 16'($urandom);
        1: lv = u ? 16'h9998 : 16'h0001;
        default: lv = to_bcd(int'($urandom_range(9999)));
      endcase
      step(r, ld, lv, e, u);
      for (int i = 0; i < 4; i++) begin
        int maxv = pow10(dig[i]) - 1;
        total++;
        if (dut_cnt[i] !== to_bcd(mval[i]) || dut_ovf[i] !== movf[i] ||
            dut_err[i] !== merr[i] || dut_z[i] !== (mval[i] == 0) ||
            dut_m[i] !== (mval[i] == maxv)) begin
          bad++;
          $display("FAIL random n=%0d inst=%0d got cnt=%h ovf=%b err=%b z=%b m=%b want cnt=%h ovf=%b err=%b",
                   n, i, dut_cnt[i], dut_ovf[i], dut_err[i], dut_z[i], dut_m[i],
                   to_bcd(mval[i]), movf[i], merr[i]);
        end
        for (int k = 0; k < 4; k++) begin
          total++;
          if (dut_cnt[i][4*k +: 4] > 4'd9) begin
            bad++;
            $display("FAIL bcd_digit n=%0d inst=%0d digit=%0d got %h want <=9",
                     n, i, k, dut_cnt[i][4*k +: 4]);
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mval[i] = 0; movf[i] = 0; merr[i] = 0;
    end
    @(negedge clk);
    test_reset();
    test_count_up();
    test_down_boundary();
    test_load_err();
    test_load_priority();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcdn_counter.md
Name: bcdn_counter

Overview:
Parametrised N-digit BCD up/down counter that generalises the team's 2-digit BCD count-up chain. Adds selectable direction, synchronous parallel load with BCD validity checking, and wrap or saturate boundary modes. Emits a registered overflow/underflow pulse for cascading or event logging. Sits in the display/timer datapath, driving 7-segment decoders directly from its packed digit output.

Parameters:
DIGITS, 4, number of BCD digits (1..8); count width is 4*DIGITS bits.
SATURATE, 0, 0 = wrap at the boundary (99..9 <-> 00..0); 1 = hold at the boundary.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
en  input  1  count enable; one step per cycle while high
up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1
load  input  1  synchronous parallel load request
load_val  input  4*DIGITS  packed BCD load value; digit 0 in bits [3:0]
count  output  4*DIGITS  packed BCD count; digit k in bits [4k+3:4k]
ovf  output  1  registered one-cycle pulse: step attempted from the boundary
load_err  output  1  registered one-cycle pulse: load rejected (invalid BCD digit)
is_zero  output  1  combinational: count == all zeros
is_max  output  1  combinational: every digit == 9

Behaviour:
- One clock; reset is synchronous and active-high: when reset=1 at a rising clk edge, count=0, ovf=0, load_err=0; all other inputs are ignored that cycle.
- Priority per edge: reset > load > en. load=1 and en=1 together: load wins, no count step, no ovf.
- Load: if every 4-bit digit of load_val is <= 9, count <= load_val next edge and load_err=0. If any digit is > 9, count is unchanged and load_err=1 for exactly the following cycle. A rejected load still suppresses counting that cycle.
- Count up (en=1, up=1, load=0): digit 0 always steps; digit k steps only if digits 0..k-1 are all 9. A stepping digit goes 9->0, otherwise +1. Result appears one edge later (latency 1).
- Count down (en=1, up=0, load=0): digit k steps only if digits 0..k-1 are all 0. A stepping digit goes 0->9, otherwise -1.
- Boundary, up from all-9s: SATURATE=0 gives count=0; SATURATE=1 holds all-9s. In both modes ovf=1 for the next cycle only.
- Boundary, down from all-0s: SATURATE=0 gives all-9s; SATURATE=1 holds 0. In both modes ovf=1 for the next cycle only.
- ovf is registered; it is high in the same cycle that count shows the wrapped or held value. Holding en=1 at a saturated boundary re-asserts ovf every cycle.
- en=0 with load=0: count holds; ovf and load_err return to 0.
- Direction change between consecutive cycles needs no recovery cycle.
- count only ever holds valid BCD; no digit is ever > 9 under any input sequence.
- is_zero and is_max derive from the current count register; with DIGITS=1 they reduce to ==0 and ==9.
- Reset asserted mid-count, or together with load/en, forces zeros on the next edge; any pending ovf/load_err pulse is cleared.

Test Plan:
- DIGITS=2, SATURATE=0: reset, then en=1 up=1 for 100 cycles -> count steps 00,01..09,10..99,00; ovf=1 only in the cycle count returns to 00; is_max high only at 99.
- DIGITS=4: load 0x1000, then en=1 up=0 for 1 cycle -> count=0x0999, ovf=0; load 0x0000, then down 1 cycle -> SATURATE=0 gives 0x9999 with ovf=1; SATURATE=1 gives 0x0000 with ovf=1 held for each further en cycle.
- DIGITS=3: load_val=0x1A5 with load=1 -> count unchanged, load_err=1 for exactly 1 cycle; load_val=0x159 -> count=0x159, load_err=0.
- DIGITS=2, count=0x37: load=1 with load_val=0x80, en=1 up=1 in the same cycle -> count=0x80, no increment; next cycle with en=1 -> 0x81.
- DIGITS=2, counting up at 0x45 with reset=1 for one cycle while en=1 and load=1 -> count=0x00, ovf=0, load_err=0; counting resumes 0x01 next cycle.
- Random mix of en/up/load (10k cycles, DIGITS=4, both SATURATE values) vs. an integer reference model mod 10^4 -> exact match of count, ovf and load_err every cycle; no digit ever > 9.
